// File: rtl/full_adder_bist_if.sv
// rtl/full_adder_bist_if.sv - control and adder-side signal bundle of the full-adder BIST engine
interface full_adder_bist_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             in_1;
  logic             in_2;
  logic             cin;
  logic             sum;
  logic             count;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output start, sum, count,
    input  in_1, in_2, cin, busy, done, pass, err_cnt
  );

  modport slave (
    input  start, sum, count,
    output in_1, in_2, cin, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/full_adder_bist.sv
// rtl/full_adder_bist.sv - BIST engine sweeping all 8 full-adder vectors for ROUNDS rounds
// and counting (saturating) responses that disagree with the truth table.
module full_adder_bist #(
  parameter int ROUNDS = 4,
  parameter int ERR_W  = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  full_adder_bist_if.slave bus
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [RW-1:0]    round_q, round_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic exp_sum;
  logic exp_count;
  logic vec_err;

  always_comb begin
    exp_sum   = ^vec_q;
    exp_count = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    vec_err   = (bus.sum != exp_sum) || (bus.count != exp_count);
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    round_d   = round_q;
    err_cnt_d = err_cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vec_d     = 3'd0;
          round_d   = '0;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (vec_err && (err_cnt_q != {ERR_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        // vec returns to 0 on the way to FINISH so the adder inputs drop with it
        if ((vec_q == 3'd7) && (round_q == LAST_ROUND)) begin
          vec_d   = 3'd0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          vec_d = vec_q + 3'd1;
          if (vec_q == 3'd7) begin
            round_d = round_q + 1'b1;
          end
          state_d = DRIVE;
        end
      end
      FINISH: begin
        pass_d  = (err_cnt_q == '0);
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      vec_q     <= 3'd0;
      round_q   <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      round_q   <= round_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.in_1    = vec_q[2];
  assign bus.in_2    = vec_q[1];
  assign bus.cin     = vec_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_full_adder_bist.sv
// tb/tb_full_adder_bist.sv - randomized self-checking bench for full_adder_bist
// with a fault-injectable behavioural adder per instance.
module tb_full_adder_bist;
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  int rnd[3] = '{1, 4, 2};
  int wid[3] = '{8, 8, 2};

  logic       st[3];
  logic [7:0] fs[3];
  logic [7:0] fc[3];
  logic [2:0] vec_o[3];
  logic       busy_o[3];
  logic       done_o[3];
  logic       pass_o[3];
  logic [7:0] err_o[3];

  int n_chk  = 0;
  int n_pass = 0;

  full_adder_bist_if #(.ERR_W(8)) bus0 ();
  full_adder_bist_if #(.ERR_W(8)) bus1 ();
  full_adder_bist_if #(.ERR_W(2)) bus2 ();

  full_adder_bist #(.ROUNDS(1), .ERR_W(8)) u_dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0.slave));
  full_adder_bist #(.ROUNDS(4), .ERR_W(8)) u_dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1.slave));
  full_adder_bist #(.ROUNDS(2), .ERR_W(2)) u_dut2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus2.slave));

  // Arithmetic adder, with per-vector bit flips to emulate faults: result is {carry, sum}
  function automatic logic [1:0] adder_model(input logic [2:0] v, input logic [7:0] fsm,
                                             input logic [7:0] fcm);
    int total;
    logic [1:0] r;
    total = int'(v[2]) + int'(v[1]) + int'(v[0]);
    r = 2'(total);
    return r ^ {fcm[v], fsm[v]};
  endfunction

  assign bus0.start = st[0];
  assign bus1.start = st[1];
  assign bus2.start = st[2];
  assign {bus0.count, bus0.sum} = adder_model({bus0.in_1, bus0.in_2, bus0.cin}, fs[0], fc[0]);
  assign {bus1.count, bus1.sum} = adder_model({bus1.in_1, bus1.in_2, bus1.cin}, fs[1], fc[1]);
  assign {bus2.count, bus2.sum} = adder_model({bus2.in_1, bus2.in_2, bus2.cin}, fs[2], fc[2]);

  assign vec_o[0] = {bus0.in_1, bus0.in_2, bus0.cin};
  assign vec_o[1] = {bus1.in_1, bus1.in_2, bus1.cin};
  assign vec_o[2] = {bus2.in_1, bus2.in_2, bus2.cin};
  assign busy_o[0] = bus0.busy;
  assign busy_o[1] = bus1.busy;
  assign busy_o[2] = bus2.busy;
  assign done_o[0] = bus0.done;
  assign done_o[1] = bus1.done;
  assign done_o[2] = bus2.done;
  assign pass_o[0] = bus0.pass;
  assign pass_o[1] = bus1.pass;
  assign pass_o[2] = bus2.pass;
  assign err_o[0] = bus0.err_cnt;
  assign err_o[1] = bus1.err_cnt;
  assign err_o[2] = 8'(bus2.err_cnt);

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int expected_err(input logic [7:0] mask, input int rounds, input int w);
    int n;
    int cap;
    n = $countones(mask) * rounds;
    cap = (1 << w) - 1;
    return (n > cap) ? cap : n;
  endfunction

  function automatic logic [7:0] sum_stuck0_mask();
    logic [7:0] m;
    for (int v = 0; v < 8; v++) m[v] = (((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)) % 2) == 1;
    return m;
  endfunction

  // One complete run on instance i; optional extra start pulses while the run is active
  task automatic run_bist(input int i, input bit poke);
    int r;
    int cyc;
    int seq_bad;
    int busy_bad;
    int idle_bad;
    int done_seen;
    int done_cyc;
    int exp_e;
    r = rnd[i];
    seq_bad = 0; busy_bad = 0; idle_bad = 0; done_seen = 0; done_cyc = -1;
    exp_e = expected_err(fs[i] | fc[i], r, wid[i]);
    @(negedge sys_clk); st[i] = 1'b1;
    @(negedge sys_clk); st[i] = 1'b0;
    for (cyc = 1; cyc <= 16 * r + 3; cyc++) begin
      if (done_o[i]) begin done_seen++; done_cyc = cyc; end
      if (cyc <= 16 * r) begin
        if (vec_o[i] != 3'(((cyc - 1) / 2) % 8)) seq_bad++;
      end else if (vec_o[i] != 3'd0) seq_bad++;
      if (cyc <= 16 * r + 1) begin
        if (!busy_o[i]) busy_bad++;
      end else if (busy_o[i]) idle_bad++;
      if (cyc == 16 * r + 2) begin
        check($sformatf("err_cnt[%0d]", i), err_o[i], exp_e);
        check($sformatf("pass[%0d]", i), pass_o[i], exp_e == 0);
      end
      st[i] = poke && (cyc == 5 || cyc == 6);
      @(negedge sys_clk);
    end
    check($sformatf("vec_seq[%0d]", i), seq_bad, 0);
    check($sformatf("busy[%0d]", i), busy_bad, 0);
    check($sformatf("idle_after[%0d]", i), idle_bad, 0);
    check($sformatf("done_count[%0d]", i), done_seen, 1);
    check($sformatf("done_cycle[%0d]", i), done_cyc, 16 * r + 1);
  endtask

  initial begin
    int ds;
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; fs[i] = 8'h00; fc[i] = 8'h00; end
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_vec[%0d]", i), vec_o[i], 0);
      check($sformatf("rst_busy[%0d]", i), busy_o[i], 0);
      check($sformatf("rst_done[%0d]", i), done_o[i], 0);
      check($sformatf("rst_pass[%0d]", i), pass_o[i], 0);
      check($sformatf("rst_err[%0d]", i), err_o[i], 0);
    end

    run_bist(0, 1'b0);
    fs[1] = sum_stuck0_mask();
    run_bist(1, 1'b0);
    check("stuck_sum_total", err_o[1], 16);
    fc[2] = 8'hFF;
    run_bist(2, 1'b0);
    check("sat_total", err_o[2], 3);
    fs[1] = 8'h00;
    run_bist(1, 1'b1);

    // Abort at vector 5 of round 0 with an asynchronous mid-cycle reset
    fs[1] = sum_stuck0_mask();
    @(negedge sys_clk); st[1] = 1'b1;
    @(negedge sys_clk); st[1] = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("pre_rst_vec", vec_o[1], 5);
    check("pre_rst_err", err_o[1], $countones(fs[1] & 8'h1F));
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_vec", vec_o[1], 0);
    check("async_rst_busy", busy_o[1], 0);
    check("async_rst_err", err_o[1], 0);
    check("async_rst_done", done_o[1], 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    ds = 0;
    repeat (70) begin @(negedge sys_clk); if (done_o[1] || busy_o[1]) ds++; end
    check("aborted_no_done", ds, 0);
    run_bist(1, 1'b0);

    // start held high: exactly one idle cycle between back-to-back runs
    @(negedge sys_clk); st[0] = 1'b1;
    repeat (17) @(negedge sys_clk);
    check("b2b_done", done_o[0], 1);
    @(negedge sys_clk);
    check("b2b_idle_gap", busy_o[0], 0);
    @(negedge sys_clk);
    check("b2b_restart", busy_o[0], 1);
    st[0] = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("b2b_second_end", busy_o[0], 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          fs[i] = 8'h00; fc[i] = 8'h00;
        end else begin
          fs[i] = 8'($urandom); fc[i] = 8'($urandom) & 8'($urandom);
        end
        run_bist(i, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
